// File: rtl/uart_tx_byte_buffer.sv
// Byte FIFO between the DMA I/O controller and the UART transmitter.
// Bytes strobed in by the DMA are stored. While the send level is high they
// are handed to the UART one at a time with a start/done pulse handshake.
// One done pulse per transmitted byte goes back to the DMA, and a timeout
// abandons a byte the UART never acknowledges.
module uart_tx_byte_buffer #(
    parameter int unsigned SIZE_BIT = 5,
    parameter logic [15:0] TIMEOUT  = 16'd50000
) (
    input  logic                i_Clock,
    input  logic                i_Reset,
    input  logic [7:0]          i_Wr_Byte,
    input  logic                i_Wr_DV,
    input  logic                i_Tx_Send,
    output logic [7:0]          o_Tx_Byte,
    output logic                o_Tx_DV,
    input  logic                i_Tx_Active,
    input  logic                i_Tx_Done,
    output logic                o_Tx_Done,
    output logic                o_Tx_Err,
    output logic [SIZE_BIT:0]   o_Count,
    output logic                o_Full,
    output logic                o_Empty,
    output logic                o_Overflow
);

    localparam logic [SIZE_BIT-1:0] PTR_ONE   = SIZE_BIT'(1);
    localparam logic [SIZE_BIT:0]   CNT_ONE   = (SIZE_BIT + 1)'(1);
    localparam logic [SIZE_BIT:0]   DEPTH_CNT = (SIZE_BIT + 1)'(2 ** SIZE_BIT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE
    } state_t;

    logic [7:0]          mem [2 ** SIZE_BIT];

    state_t              state_q,    state_d;
    logic [SIZE_BIT-1:0] wr_ptr_q,   wr_ptr_d;
    logic [SIZE_BIT-1:0] rd_ptr_q,   rd_ptr_d;
    logic [SIZE_BIT:0]   count_q,    count_d;
    logic [15:0]         timer_q,    timer_d;
    logic [7:0]          tx_byte_q,  tx_byte_d;
    logic                tx_done_q,  tx_done_d;
    logic                tx_err_q,   tx_err_d;
    logic                overflow_q, overflow_d;

    logic                push;
    logic                pop;
    logic                full;
    logic                empty;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);

    // Next-state logic: FIFO write side, drain FSM and occupancy count.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        timer_d    = timer_q;
        tx_byte_d  = tx_byte_q;
        tx_done_d  = 1'b0;
        tx_err_d   = 1'b0;
        overflow_d = overflow_q;
        push       = 1'b0;
        pop        = 1'b0;

        // Full is judged on the pre-edge count, so a write at full is lost
        // even when a pop happens in the same cycle.
        if (i_Wr_DV) begin
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                push     = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
        end

        case (state_q)
            IDLE: begin
                if (i_Tx_Send && !empty && !i_Tx_Active) begin
                    pop       = 1'b1;
                    tx_byte_d = mem[rd_ptr_q];
                    rd_ptr_d  = rd_ptr_q + PTR_ONE;
                    state_d   = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_Tx_Done) begin
                    tx_done_d = 1'b1;
                    state_d   = IDLE;
                end else if (timer_q == TIMEOUT - 16'd1) begin
                    tx_err_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // State and control registers with synchronous active-low reset.
    always_ff @(posedge i_Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!i_Reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            timer_q    <= '0;
            tx_byte_q  <= 8'h00;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            tx_byte_q  <= tx_byte_d;
            tx_done_q  <= tx_done_d;
            tx_err_q   <= tx_err_d;
            overflow_q <= overflow_d;
        end
    end

    // Byte storage.
    always_ff @(posedge i_Clock) begin
        // NOTE: the array is deliberately not reset; the pointers and count
        // define which entries are valid, so stale data is never read.
        if (push) begin
            mem[wr_ptr_q] <= i_Wr_Byte;
        end
    end

    assign o_Tx_Byte  = tx_byte_q;
    assign o_Tx_DV    = (state_q == START);
    assign o_Tx_Done  = tx_done_q;
    assign o_Tx_Err   = tx_err_q;
    assign o_Count    = count_q;
    assign o_Full     = full;
    assign o_Empty    = empty;
    assign o_Overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_byte_buffer.sv
// Self-checking bench for uart_tx_byte_buffer. A scoreboard queue holds the
// bytes expected on the UART side. Each test is a task that drives stimulus
// and checks its own results. A second instance with a short timeout and a
// silent UART covers the abandon path.
module tb_uart_tx_byte_buffer;

    localparam int unsigned SB       = 2;
    localparam int          DEPTH    = 4;
    localparam int          UART_LAT = 10;

    logic          clk = 1'b0;
    logic          i_Reset = 1'b0;
    logic [7:0]    i_Wr_Byte = 8'h00;
    logic          i_Wr_DV = 1'b0;
    logic          i_Tx_Send = 1'b0;
    logic          i_Tx_Active = 1'b0;
    logic          i_Tx_Done = 1'b0;
    logic          to_send = 1'b0;

    logic [7:0]    o_Tx_Byte;
    logic          o_Tx_DV, o_Tx_Done, o_Tx_Err, o_Full, o_Empty, o_Overflow;
    logic [SB:0]   o_Count;

    logic [7:0]    to_tx_byte;
    logic          to_tx_dv, to_tx_done, to_tx_err, to_full, to_empty, to_overflow;
    logic [SB:0]   to_count;

    int            checks = 0;
    int            passes = 0;
    logic [7:0]    exp_q[$];
    logic [7:0]    exp_b;
    int            model_cnt = 0;
    bit            uart_en = 1'b0;
    bit            manual_done = 1'b0;
    int            uart_cnt = 0;
    int            dv_cnt = 0;
    int            done_cnt = 0;
    int            to_done_cnt = 0;
    int            to_err_cnt = 0;

    always #5 clk = ~clk;

    uart_tx_byte_buffer #(.SIZE_BIT(SB), .TIMEOUT(16'd16)) dut (
        .i_Clock(clk), .i_Reset(i_Reset), .i_Wr_Byte(i_Wr_Byte), .i_Wr_DV(i_Wr_DV),
        .i_Tx_Send(i_Tx_Send), .o_Tx_Byte(o_Tx_Byte), .o_Tx_DV(o_Tx_DV),
        .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done), .o_Tx_Done(o_Tx_Done),
        .o_Tx_Err(o_Tx_Err), .o_Count(o_Count), .o_Full(o_Full), .o_Empty(o_Empty),
        .o_Overflow(o_Overflow)
    );

    uart_tx_byte_buffer #(.SIZE_BIT(SB), .TIMEOUT(16'd8)) dut_to (
        .i_Clock(clk), .i_Reset(i_Reset), .i_Wr_Byte(i_Wr_Byte), .i_Wr_DV(i_Wr_DV),
        .i_Tx_Send(to_send), .o_Tx_Byte(to_tx_byte), .o_Tx_DV(to_tx_dv),
        .i_Tx_Active(1'b0), .i_Tx_Done(1'b0), .o_Tx_Done(to_tx_done),
        .o_Tx_Err(to_tx_err), .o_Count(to_count), .o_Full(to_full), .o_Empty(to_empty),
        .o_Overflow(to_overflow)
    );

    // UART model and scoreboard: every start pulse pops one expected byte.
    always @(negedge clk) begin
        i_Tx_Done = manual_done;
        if (uart_cnt > 0) begin
            uart_cnt = uart_cnt - 1;
            if (uart_cnt == 0) i_Tx_Done = 1'b1;
        end
        if (o_Tx_DV === 1'b1) begin
            dv_cnt = dv_cnt + 1;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_byte: got %02h, expected no byte", o_Tx_Byte);
            end else begin
                exp_b = exp_q.pop_front();
                if (o_Tx_Byte !== exp_b) $display("FAIL sb_byte: got %02h, expected %02h", o_Tx_Byte, exp_b);
                else passes = passes + 1;
            end
            if (uart_en) uart_cnt = UART_LAT;
        end
        if (o_Tx_Done === 1'b1) done_cnt = done_cnt + 1;
        if (to_tx_done === 1'b1) to_done_cnt = to_done_cnt + 1;
        if (to_tx_err === 1'b1) to_err_cnt = to_err_cnt + 1;
        i_Tx_Active = (uart_cnt > 0);
    end

    task automatic do_reset();
        @(negedge clk);
        i_Reset = 1'b0;
        @(negedge clk);
        i_Reset = 1'b1;
        exp_q.delete();
        model_cnt = 0;
    endtask

    task automatic wr(input logic [7:0] b);
        i_Wr_Byte = b;
        i_Wr_DV   = 1'b1;
        @(negedge clk);
        i_Wr_DV   = 1'b0;
        if (model_cnt < DEPTH) begin
            exp_q.push_back(b);
            model_cnt = model_cnt + 1;
        end
    endtask

    task automatic wait_dones(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_Reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (o_Tx_Byte !== 8'h00) $display("FAIL rst_byte: got %02h, expected 00", o_Tx_Byte); else passes++;
        checks++; if (o_Tx_DV !== 1'b0) $display("FAIL rst_dv: got %b, expected 0", o_Tx_DV); else passes++;
        checks++; if (o_Tx_Done !== 1'b0) $display("FAIL rst_done: got %b, expected 0", o_Tx_Done); else passes++;
        checks++; if (o_Tx_Err !== 1'b0) $display("FAIL rst_err: got %b, expected 0", o_Tx_Err); else passes++;
        checks++; if (o_Overflow !== 1'b0) $display("FAIL rst_ovf: got %b, expected 0", o_Overflow); else passes++;
        checks++; if (o_Empty !== 1'b1) $display("FAIL rst_empty: got %b, expected 1", o_Empty); else passes++;
        checks++; if (o_Full !== 1'b0) $display("FAIL rst_full: got %b, expected 0", o_Full); else passes++;
        checks++; if (o_Count !== 3'd0) $display("FAIL rst_count: got %0d, expected 0", o_Count); else passes++;
        i_Reset = 1'b1;
    endtask

    task automatic test_drain();
        int dv_base;
        int done_base;
        bit ok;
        do_reset();
        uart_en   = 1'b1;
        dv_base   = dv_cnt;
        done_base = done_cnt;
        wr(8'h11); wr(8'h22); wr(8'h33);
        checks++; if (o_Count !== 3'd3) $display("FAIL fill_count: got %0d, expected 3", o_Count); else passes++;
        checks++; if (o_Empty !== 1'b0) $display("FAIL fill_empty: got %b, expected 0", o_Empty); else passes++;
        checks++; if (o_Tx_DV !== 1'b0) $display("FAIL fill_no_dv: got %b, expected 0", o_Tx_DV); else passes++;
        i_Tx_Send = 1'b1;
        @(negedge clk);
        checks++; if (o_Tx_DV !== 1'b1) $display("FAIL dv_latency: got %b, expected 1", o_Tx_DV); else passes++;
        wait_dones(done_base + 3, 120, ok);
        checks++; if (!ok) $display("FAIL drain_timeout: got %0d dones, expected 3", done_cnt - done_base); else passes++;
        i_Tx_Send = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        model_cnt = 0;
        checks++; if (dv_cnt - dv_base !== 3) $display("FAIL drain_dv_cnt: got %0d, expected 3", dv_cnt - dv_base); else passes++;
        checks++; if (done_cnt - done_base !== 3) $display("FAIL drain_done_cnt: got %0d, expected 3", done_cnt - done_base); else passes++;
        checks++; if (o_Count !== 3'd0) $display("FAIL drain_count: got %0d, expected 0", o_Count); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL drain_left: got %0d bytes pending, expected 0", exp_q.size()); else passes++;
    endtask

    task automatic test_overflow_wrap();
        int done_base;
        bit ok;
        do_reset();
        uart_en = 1'b1;
        wr(8'hA0); wr(8'hA1); wr(8'hA2);
        checks++; if (o_Full !== 1'b0) $display("FAIL ovf_full3: got %b, expected 0", o_Full); else passes++;
        wr(8'hA3);
        checks++; if (o_Full !== 1'b1) $display("FAIL ovf_full4: got %b, expected 1", o_Full); else passes++;
        checks++; if (o_Overflow !== 1'b0) $display("FAIL ovf_early: got %b, expected 0", o_Overflow); else passes++;
        wr(8'hA4);
        checks++; if (o_Overflow !== 1'b1) $display("FAIL ovf_set: got %b, expected 1", o_Overflow); else passes++;
        checks++; if (o_Count !== 3'd4) $display("FAIL ovf_count: got %0d, expected 4", o_Count); else passes++;
        for (int round = 0; round < 3; round++) begin
            if (round == 1) begin wr(8'hB0); wr(8'hB1); wr(8'hB2); end
            if (round == 2) begin wr(8'hB3); wr(8'hB4); wr(8'hB5); end
            done_base = done_cnt;
            i_Tx_Send = 1'b1;
            wait_dones(done_base + ((round == 0) ? 4 : 3), 150, ok);
            i_Tx_Send = 1'b0;
            model_cnt = 0;
            checks++; if (!ok) $display("FAIL wrap_drain%0d: got %0d dones, expected more", round, done_cnt - done_base); else passes++;
        end
        repeat (2) @(negedge clk);
        checks++; if (o_Overflow !== 1'b1) $display("FAIL ovf_sticky: got %b, expected 1", o_Overflow); else passes++;
        checks++; if (o_Count !== 3'd0) $display("FAIL wrap_count: got %0d, expected 0", o_Count); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL wrap_left: got %0d bytes pending, expected 0", exp_q.size()); else passes++;
    endtask

    task automatic test_back_to_back();
        int done_base;
        bit ok;
        do_reset();
        uart_en = 1'b1;
        wr(8'hC0); wr(8'hC1);
        checks++; if (o_Count !== 3'd2) $display("FAIL b2b_pre: got %0d, expected 2", o_Count); else passes++;
        done_base = done_cnt;
        i_Wr_Byte = 8'hC2;
        i_Wr_DV   = 1'b1;
        i_Tx_Send = 1'b1;
        exp_q.push_back(8'hC2);
        @(negedge clk);
        i_Wr_DV = 1'b0;
        checks++; if (o_Count !== 3'd2) $display("FAIL b2b_count: got %0d, expected 2", o_Count); else passes++;
        checks++; if (o_Tx_DV !== 1'b1) $display("FAIL b2b_dv: got %b, expected 1", o_Tx_DV); else passes++;
        wait_dones(done_base + 3, 120, ok);
        i_Tx_Send = 1'b0;
        checks++; if (!ok) $display("FAIL b2b_drain: got %0d dones, expected 3", done_cnt - done_base); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL b2b_left: got %0d bytes pending, expected 0", exp_q.size()); else passes++;
    endtask

    task automatic test_timeout();
        int  err_base;
        int  tdone_base;
        bit  early;
        do_reset();
        wr(8'hD0); wr(8'hD1);
        err_base   = to_err_cnt;
        tdone_base = to_done_cnt;
        checks++; if (to_count !== 3'd2) $display("FAIL to_count: got %0d, expected 2", to_count); else passes++;
        to_send = 1'b1;
        @(negedge clk);
        checks++; if (to_tx_dv !== 1'b1) $display("FAIL to_dv0: got %b, expected 1", to_tx_dv); else passes++;
        checks++; if (to_tx_byte !== 8'hD0) $display("FAIL to_byte0: got %02h, expected d0", to_tx_byte); else passes++;
        early = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (to_tx_err !== 1'b0) early = 1'b1;
        end
        checks++; if (early) $display("FAIL to_early_err: got 1, expected 0 before 8 cycles"); else passes++;
        @(negedge clk);
        checks++; if (to_tx_err !== 1'b1) $display("FAIL to_err: got %b, expected 1", to_tx_err); else passes++;
        @(negedge clk);
        #1;
        checks++; if (to_tx_err !== 1'b0) $display("FAIL to_err_width: got %b, expected 0", to_tx_err); else passes++;
        checks++; if (to_err_cnt - err_base !== 1) $display("FAIL to_err_once: got %0d, expected 1", to_err_cnt - err_base); else passes++;
        checks++; if (to_tx_dv !== 1'b1) $display("FAIL to_dv1: got %b, expected 1", to_tx_dv); else passes++;
        checks++; if (to_tx_byte !== 8'hD1) $display("FAIL to_byte1: got %02h, expected d1", to_tx_byte); else passes++;
        to_send = 1'b0;
        repeat (14) @(negedge clk);
        #1;
        checks++; if (to_err_cnt - err_base !== 2) $display("FAIL to_err_total: got %0d, expected 2", to_err_cnt - err_base); else passes++;
        checks++; if (to_done_cnt != tdone_base) $display("FAIL to_no_done: got %0d, expected 0", to_done_cnt - tdone_base); else passes++;
        checks++; if (to_empty !== 1'b1) $display("FAIL to_empty: got %b, expected 1", to_empty); else passes++;
    endtask

    task automatic test_reset_midtransfer();
        int done_base;
        do_reset();
        uart_en = 1'b0;
        wr(8'hE0); wr(8'hE1); wr(8'hE2);
        i_Tx_Send = 1'b1;
        @(negedge clk);
        checks++; if (o_Tx_DV !== 1'b1) $display("FAIL mid_dv: got %b, expected 1", o_Tx_DV); else passes++;
        repeat (3) @(negedge clk);
        done_base = done_cnt;
        checks++; if (o_Count !== 3'd2) $display("FAIL mid_count: got %0d, expected 2", o_Count); else passes++;
        i_Reset   = 1'b0;
        i_Tx_Send = 1'b0;
        @(negedge clk);
        checks++; if (o_Count !== 3'd0) $display("FAIL mid_rst_count: got %0d, expected 0", o_Count); else passes++;
        checks++; if (o_Empty !== 1'b1) $display("FAIL mid_rst_empty: got %b, expected 1", o_Empty); else passes++;
        checks++; if (o_Tx_Byte !== 8'h00) $display("FAIL mid_rst_byte: got %02h, expected 00", o_Tx_Byte); else passes++;
        i_Reset = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        manual_done = 1'b1;
        repeat (2) @(negedge clk);
        manual_done = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (done_cnt != done_base) $display("FAIL mid_no_done: got %0d, expected 0", done_cnt - done_base); else passes++;
        checks++; if (o_Tx_DV !== 1'b0) $display("FAIL mid_no_dv: got %b, expected 0", o_Tx_DV); else passes++;
        uart_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_drain();
        test_overflow_wrap();
        test_back_to_back();
        test_timeout();
        test_reset_midtransfer();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_byte_buffer.md
Name: uart_tx_byte_buffer

Overview:
- Byte FIFO sitting directly downstream of the DMA I/O controller and upstream of the UART transmitter.
- Accepts bytes strobed by the DMA (byte + data-valid) and stores them.
- While the DMA's send-trigger level is high, drains bytes one at a time to the UART TX with a start-pulse / done-pulse handshake.
- Returns one done pulse per transmitted byte, which the DMA uses to decrement its data counter.

Parameters:
- SIZE_BIT, 5, log2 of FIFO depth; DEPTH = 2**SIZE_BIT bytes; matches the DMA counter width SIZE_BIT+1.
- TIMEOUT, 16'd50000, clock cycles to wait for i_Tx_Done before abandoning a byte.

Ports:
- i_Clock  input  1  system clock, all logic on rising edge
- i_Reset  input  1  synchronous reset, active-low
- i_Wr_Byte  input  8  byte from DMA
- i_Wr_DV  input  1  write strobe; one byte captured per high cycle
- i_Tx_Send  input  1  level; drain permitted while high
- o_Tx_Byte  output  8  byte presented to UART TX
- o_Tx_DV  output  1  one-cycle start pulse to UART TX
- i_Tx_Active  input  1  UART TX busy
- i_Tx_Done  input  1  UART TX one-cycle completion pulse
- o_Tx_Done  output  1  one-cycle pulse per completed byte, to DMA
- o_Tx_Err  output  1  one-cycle pulse on timeout
- o_Count  output  SIZE_BIT+1  bytes currently stored, range 0..DEPTH
- o_Full  output  1  o_Count == DEPTH
- o_Empty  output  1  o_Count == 0
- o_Overflow  output  1  sticky; set when a write is dropped

Behaviour:
Reset
- i_Reset low at a rising edge: pointers 0, count 0, state IDLE, timer 0.
- Outputs after reset: o_Tx_Byte 8'h00; o_Tx_DV, o_Tx_Done, o_Tx_Err, o_Overflow all 0; o_Empty 1; o_Full 0.
- Reset mid-transfer abandons the byte in flight; no o_Tx_Done is issued for it.
- Stored FIFO contents are discarded (the memory array is not cleared).

FIFO write side
- Write happens when i_Wr_DV=1 and o_Full=0: mem[wr_ptr] <= i_Wr_Byte; wr_ptr increments.
- Write with o_Full=1 is dropped and o_Overflow <= 1.
- o_Full is evaluated on the pre-edge count. A write at full is dropped even if a pop happens in the same cycle.
- wr_ptr and rd_ptr are SIZE_BIT bits wide and wrap naturally DEPTH-1 -> 0.

Count arithmetic
- push only: +1
- pop only: -1
- push and pop in the same cycle: unchanged
- o_Full and o_Empty are decoded combinationally from o_Count.

FSM
IDLE
- If i_Tx_Send=1, o_Empty=0 and i_Tx_Active=0: pop (o_Tx_Byte <= mem[rd_ptr]; rd_ptr++; count--), go to START.
- Otherwise stay in IDLE.
START
- o_Tx_DV=1 for exactly this one cycle; o_Tx_Byte is stable.
- Clear timer; go to WAIT_DONE.
WAIT_DONE
- o_Tx_Byte is held.
- If i_Tx_Done=1: o_Tx_Done <= 1 for one cycle; go to IDLE.
- Else if timer == TIMEOUT-1: o_Tx_Err <= 1 for one cycle; go to IDLE. The byte is lost and no o_Tx_Done is issued.
- Otherwise timer increments.

Latency and handshake rules
- Condition sampled at edge N: o_Tx_DV high in cycle N+1.
- i_Tx_Done at edge M: o_Tx_Done high in cycle M+1.
- Minimum per-byte spacing is START + WAIT_DONE + IDLE re-check: at least 3 cycles plus the UART time.
- i_Tx_Done outside WAIT_DONE is ignored.
- i_Tx_Send falling during START/WAIT_DONE: the current byte completes normally; no new pop.
- i_Tx_Send high with the FIFO empty: remain in IDLE with no outputs.
- Writes are accepted in every state, including during drain.

Test Plan:
- Reset, write 3 bytes 0x11,0x22,0x33 with i_Tx_Send=0 -> o_Count=3, o_Empty=0, no o_Tx_DV.
- Raise i_Tx_Send, UART model returns i_Tx_Done 10 cycles after each o_Tx_DV -> o_Tx_Byte sequence 0x11,0x22,0x33; exactly 3 o_Tx_DV and 3 o_Tx_Done pulses; o_Count ends 0; o_Tx_DV one cycle after the sampled condition.
- SIZE_BIT=2: write 5 bytes 0xA0..0xA4 -> o_Full=1 after 4, 0xA4 dropped, o_Overflow=1 and stays 1; drain yields 0xA0..0xA3; wrap verified by writing and draining 6 more.
- Simultaneous i_Wr_DV and IDLE pop at count=2 -> o_Count stays 2; byte order preserved.
- TIMEOUT=8, UART never returns i_Tx_Done -> o_Tx_Err pulses once 8 cycles after entering WAIT_DONE; no o_Tx_Done; the next byte starts if i_Tx_Send is still high.
- Reset asserted in WAIT_DONE with 2 bytes queued -> next cycle o_Count=0, o_Empty=1, no o_Tx_Done; later i_Tx_Done is ignored.
